// File: rtl/adc_lvds_pkg.sv
// Shared types and helpers for the LVDS ADC receive path.
package adc_lvds_pkg;

  // Per-lane frame-alignment state.
  typedef enum logic [2:0] {
    LaneIdle   = 3'd0,
    LaneCheck  = 3'd1,
    LaneSlip   = 3'd2,
    LaneSettle = 3'd3,
    LaneLocked = 3'd4,
    LaneFail   = 3'd5
  } laneState_e;

  // Default frame-clock word: seven ones followed by seven zeros in the low 14 bits.
  localparam logic [15:0] FrmPatternDef = 16'b0011111110000000;

  // Bits needed to hold a counter that runs 0..maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/adc_frame_lane.sv
// One frame lane: compares the deserialised frame word to the pattern and
// drives bitslip until the lane locks or runs out of slips.
//
// state      | meaning
// -----------+------------------------------------------------------------
// LaneIdle   | waiting for bit-clock alignment
// LaneCheck  | comparing words; counts consecutive matches towards lock
// LaneSlip   | one-cycle bitslip pulse to the ISERDES
// LaneSettle | let the ISERDES output settle after a slip
// LaneLocked | aligned; counts consecutive misses towards loss of lock
// LaneFail   | slip budget exhausted; waits for realign or bit-clock drop
module adc_frame_lane
  import adc_lvds_pkg::*;
#(
  parameter int          AdcBits      = 14,
  parameter logic [15:0] FrmPattern   = FrmPatternDef,
  parameter int          SettleCycles = 3,
  parameter int          LockCount    = 2,
  parameter int          LossCount    = 4,
  parameter int          MaxSlips     = 2 * AdcBits
) (
  input  logic               FrmClkDiv,
  input  logic               FrmRstN,
  input  logic               BitClkDone,
  input  logic               FrmRealign,
  input  logic [AdcBits-1:0] FrmWord,
  output logic               FrmBitslip,
  output logic               FrmAlignDone,
  output logic               FrmAlignErr,
  output logic               alignDoneNext
);

  localparam int MatchW  = cntWidth(LockCount);
  localparam int MissW   = cntWidth(LossCount);
  localparam int SlipW   = cntWidth(MaxSlips);
  localparam int SettleW = cntWidth(SettleCycles);

  localparam logic [MatchW-1:0]  MatchLast  = MatchW'(LockCount - 1);
  localparam logic [MissW-1:0]   MissLast   = MissW'(LossCount - 1);
  localparam logic [SlipW-1:0]   SlipMax    = SlipW'(MaxSlips);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SettleCycles - 1);

  laneState_e         state, stateNext;
  logic [MatchW-1:0]  matchCnt, matchNext;
  logic [MissW-1:0]   missCnt, missNext;
  logic [SlipW-1:0]   slipCnt, slipNext;
  logic [SettleW-1:0] settleCnt, settleNext;
  logic               wordMatch;

  assign wordMatch     = (FrmWord == FrmPattern[AdcBits-1:0]);
  assign alignDoneNext = (stateNext == LaneLocked);

  // Next-state and counter update, highest-priority conditions first.
  always_comb begin
    stateNext  = state;
    matchNext  = matchCnt;
    missNext   = missCnt;
    slipNext   = slipCnt;
    settleNext = settleCnt;
    if (!BitClkDone) begin
      stateNext  = LaneIdle;
      matchNext  = '0;
      missNext   = '0;
      slipNext   = '0;
      settleNext = '0;
    end else if (FrmRealign && (state != LaneIdle)) begin
      stateNext  = LaneCheck;
      matchNext  = '0;
      missNext   = '0;
      slipNext   = '0;
      settleNext = '0;
    end else begin
      case (state)
        LaneIdle: begin
          stateNext = LaneCheck;
          matchNext = '0;
          missNext  = '0;
          slipNext  = '0;
        end
        LaneCheck: begin
          if (wordMatch) begin
            matchNext = matchCnt + MatchW'(1);
            if (matchCnt == MatchLast) begin
              stateNext = LaneLocked;
            end
          end else begin
            matchNext = '0;
            stateNext = (slipCnt == SlipMax) ? LaneFail : LaneSlip;
          end
        end
        LaneSlip: begin
          slipNext   = slipCnt + SlipW'(1);
          settleNext = SettleLoad;
          stateNext  = LaneSettle;
        end
        LaneSettle: begin
          // SETTLE->CHECK keeps the slip count so the budget spans the whole search.
          if (settleCnt == '0) begin
            stateNext = LaneCheck;
            matchNext = '0;
            missNext  = '0;
          end else begin
            settleNext = settleCnt - SettleW'(1);
          end
        end
        LaneLocked: begin
          if (wordMatch) begin
            missNext = '0;
          end else if (missCnt == MissLast) begin
            stateNext = LaneCheck;
            matchNext = '0;
            missNext  = '0;
            slipNext  = '0;
          end else begin
            missNext = missCnt + MissW'(1);
          end
        end
        LaneFail: begin
          stateNext = LaneFail;
        end
        default: begin
          stateNext = LaneIdle;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs decode the next state so they line up with it.
  always_ff @(posedge FrmClkDiv) begin
    if (!FrmRstN) begin
      state        <= LaneIdle;
      matchCnt     <= '0;
      missCnt      <= '0;
      slipCnt      <= '0;
      settleCnt    <= '0;
      FrmBitslip   <= 1'b0;
      FrmAlignDone <= 1'b0;
      FrmAlignErr  <= 1'b0;
    end else begin
      state        <= stateNext;
      matchCnt     <= matchNext;
      missCnt      <= missNext;
      slipCnt      <= slipNext;
      settleCnt    <= settleNext;
      FrmBitslip   <= (stateNext == LaneSlip);
      FrmAlignDone <= (stateNext == LaneLocked);
      FrmAlignErr  <= (stateNext == LaneFail);
    end
  end

endmodule

// File: rtl/adc_frame_align.sv
// Multi-lane frame alignment: one independent lane controller per ADC
// frame lane plus a registered all-lanes-locked flag.
module adc_frame_align
  import adc_lvds_pkg::*;
#(
  parameter int          AdcBits      = 14,
  parameter int          NumFrm       = 1,
  parameter logic [15:0] FrmPattern   = FrmPatternDef,
  parameter int          SettleCycles = 3,
  parameter int          LockCount    = 2,
  parameter int          LossCount    = 4,
  parameter int          MaxSlips     = 2 * AdcBits
) (
  input  logic                      FrmClkDiv,
  input  logic                      FrmRstN,
  input  logic                      BitClkDone,
  input  logic                      FrmRealign,
  input  logic [NumFrm*AdcBits-1:0] FrmWord,
  output logic [NumFrm-1:0]         FrmBitslip,
  output logic [NumFrm-1:0]         FrmAlignDone,
  output logic [NumFrm-1:0]         FrmAlignErr,
  output logic                      FrmAllDone
);

  logic [NumFrm-1:0] doneNext;

  for (genvar i = 0; i < NumFrm; i++) begin : gLane
    adc_frame_lane #(
      .AdcBits      (AdcBits),
      .FrmPattern   (FrmPattern),
      .SettleCycles (SettleCycles),
      .LockCount    (LockCount),
      .LossCount    (LossCount),
      .MaxSlips     (MaxSlips)
    ) uLane (
      .FrmClkDiv     (FrmClkDiv),
      .FrmRstN       (FrmRstN),
      .BitClkDone    (BitClkDone),
      .FrmRealign    (FrmRealign),
      .FrmWord       (FrmWord[i*AdcBits +: AdcBits]),
      .FrmBitslip    (FrmBitslip[i]),
      .FrmAlignDone  (FrmAlignDone[i]),
      .FrmAlignErr   (FrmAlignErr[i]),
      .alignDoneNext (doneNext[i])
    );
  end

  // All-lanes-locked, built from next-state so it changes on the same edge as FrmAlignDone.
  always_ff @(posedge FrmClkDiv) begin
    if (!FrmRstN) begin
      FrmAllDone <= 1'b0;
    end else begin
      FrmAllDone <= &doneNext;
    end
  end

endmodule

// File: tb/tb_adc_frame_align.sv
// Directed bench for adc_frame_align with two lanes and an ISERDES model
// whose rotation steps once per observed bitslip pulse.
module tb_adc_frame_align;

  localparam int AdcBits = 14;
  localparam int NumFrm  = 2;
  localparam logic [AdcBits-1:0] Pat = 14'h3F80;

  logic                      FrmClkDiv = 1'b0;
  logic                      FrmRstN;
  logic                      BitClkDone;
  logic                      FrmRealign;
  logic [NumFrm*AdcBits-1:0] FrmWord;
  logic [NumFrm-1:0]         FrmBitslip;
  logic [NumFrm-1:0]         FrmAlignDone;
  logic [NumFrm-1:0]         FrmAlignErr;
  logic                      FrmAllDone;

  int compared   = 0;
  int mismatched = 0;

  int slipSeen [NumFrm];
  int slipBase [NumFrm];
  int baseOff  [NumFrm];
  bit garbage  [NumFrm];
  bit corrupt  [NumFrm];
  bit [NumFrm-1:0] prevSlip;
  bit wideSlip;

  adc_frame_align #(
    .AdcBits (AdcBits),
    .NumFrm  (NumFrm)
  ) dut (
    .FrmClkDiv    (FrmClkDiv),
    .FrmRstN      (FrmRstN),
    .BitClkDone   (BitClkDone),
    .FrmRealign   (FrmRealign),
    .FrmWord      (FrmWord),
    .FrmBitslip   (FrmBitslip),
    .FrmAlignDone (FrmAlignDone),
    .FrmAlignErr  (FrmAlignErr),
    .FrmAllDone   (FrmAllDone)
  );

  always #5 FrmClkDiv = ~FrmClkDiv;

  function automatic logic [AdcBits-1:0] laneWord(input int off, input int slips,
                                                  input bit g, input bit c);
    logic [2*AdcBits-1:0] d;
    logic [AdcBits-1:0]   w;
    int k;
    k = ((off - slips) % AdcBits + AdcBits) % AdcBits;
    d = {Pat, Pat} << k;
    w = g ? '0 : d[2*AdcBits-1 -: AdcBits];
    if (c) w = w ^ 14'h0001;
    return w;
  endfunction

  // ISERDES model: word rotation follows the bitslip pulses seen so far.
  always_comb begin
    FrmWord = '0;
    for (int i = 0; i < NumFrm; i++) begin
      FrmWord[i*AdcBits +: AdcBits] = laneWord(baseOff[i], slipSeen[i] - slipBase[i],
                                               garbage[i], corrupt[i]);
    end
  end

  // Count bitslip pulses per lane and flag any pulse longer than one cycle.
  always @(posedge FrmClkDiv) begin
    for (int i = 0; i < NumFrm; i++) begin
      if (FrmBitslip[i] === 1'b1) slipSeen[i] <= slipSeen[i] + 1;
    end
    prevSlip <= FrmBitslip;
    if ((FrmBitslip & prevSlip) != '0) wideSlip <= 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge FrmClkDiv);
    #1;
  endtask

  task automatic prep(input int off0, input int off1, input bit g0, input bit g1);
    BitClkDone = 1'b0;
    FrmRealign = 1'b0;
    step(1);
    baseOff[0] = off0;  baseOff[1] = off1;
    garbage[0] = g0;    garbage[1] = g1;
    corrupt[0] = 1'b0;  corrupt[1] = 1'b0;
    slipBase[0] = slipSeen[0];
    slipBase[1] = slipSeen[1];
    step(1);
  endtask

  task automatic test_reset();
    FrmRstN = 1'b0; BitClkDone = 1'b0; FrmRealign = 1'b0;
    step(3);
    compared++; if (FrmBitslip !== 2'b00) begin mismatched++; $display("FAIL reset_bitslip: got %b want 00", FrmBitslip); end
    compared++; if (FrmAlignDone !== 2'b00) begin mismatched++; $display("FAIL reset_done: got %b want 00", FrmAlignDone); end
    compared++; if (FrmAlignErr !== 2'b00) begin mismatched++; $display("FAIL reset_err: got %b want 00", FrmAlignErr); end
    compared++; if (FrmAllDone !== 1'b0) begin mismatched++; $display("FAIL reset_alldone: got %b want 0", FrmAllDone); end
    FrmRstN = 1'b1;
    step(1);
  endtask

  task automatic test_aligned();
    int pulses = 0;
    prep(0, 0, 1'b0, 1'b0);
    BitClkDone = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (FrmBitslip != 2'b00) pulses++;
      if (k == 2) begin
        compared++; if (FrmAlignDone !== 2'b00) begin mismatched++; $display("FAIL aligned_early_done: got %b want 00", FrmAlignDone); end
      end
      if (k == 3) begin
        compared++; if (FrmAlignDone !== 2'b11) begin mismatched++; $display("FAIL aligned_done: got %b want 11", FrmAlignDone); end
        compared++; if (FrmAllDone !== 1'b1) begin mismatched++; $display("FAIL aligned_alldone: got %b want 1", FrmAllDone); end
      end
    end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL aligned_no_slip: got %0d want 0", pulses); end
  endtask

  task automatic test_rotated();
    int cyc [8];
    int n = 0;
    prep(3, 3, 1'b0, 1'b0);
    BitClkDone = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step(1);
      if (FrmBitslip[0] === 1'b1 && n < 8) begin cyc[n] = k; n++; end
      if (k == 17) begin
        compared++; if (FrmAlignDone[0] !== 1'b0) begin mismatched++; $display("FAIL rot_early_done: got %b want 0", FrmAlignDone[0]); end
      end
      if (k == 18) begin
        compared++; if (FrmAlignDone !== 2'b11) begin mismatched++; $display("FAIL rot_done: got %b want 11", FrmAlignDone); end
        compared++; if (FrmAllDone !== 1'b1) begin mismatched++; $display("FAIL rot_alldone: got %b want 1", FrmAllDone); end
      end
    end
    compared++; if (n !== 3) begin mismatched++; $display("FAIL rot_pulse_count: got %0d want 3", n); end
    if (n >= 1) begin
      compared++; if (cyc[0] !== 2) begin mismatched++; $display("FAIL rot_first_latency: got %0d want 2", cyc[0]); end
    end
    for (int i = 1; i < n && i < 3; i++) begin
      compared++; if (cyc[i] - cyc[i-1] !== 5) begin mismatched++; $display("FAIL rot_spacing: got %0d want 5", cyc[i] - cyc[i-1]); end
    end
  endtask

  task automatic test_fail_and_realign();
    int pulses = 0;
    prep(0, 0, 1'b1, 1'b1);
    BitClkDone = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      step(1);
      if (FrmBitslip[0] === 1'b1) pulses++;
      if (k == 141) begin
        compared++; if (FrmAlignErr[0] !== 1'b0) begin mismatched++; $display("FAIL fail_early_err: got %b want 0", FrmAlignErr[0]); end
      end
      if (k == 142) begin
        compared++; if (FrmAlignErr !== 2'b11) begin mismatched++; $display("FAIL fail_err: got %b want 11", FrmAlignErr); end
      end
    end
    compared++; if (pulses !== 28) begin mismatched++; $display("FAIL fail_pulse_count: got %0d want 28", pulses); end
    compared++; if (FrmAlignErr !== 2'b11) begin mismatched++; $display("FAIL fail_err_sticky: got %b want 11", FrmAlignErr); end
    compared++; if (FrmAlignDone !== 2'b00) begin mismatched++; $display("FAIL fail_done: got %b want 00", FrmAlignDone); end
    garbage[0] = 1'b0; garbage[1] = 1'b0;
    baseOff[0] = 0;    baseOff[1] = 0;
    slipBase[0] = slipSeen[0];
    slipBase[1] = slipSeen[1];
    FrmRealign = 1'b1;
    step(1);
    FrmRealign = 1'b0;
    compared++; if (FrmAlignErr !== 2'b00) begin mismatched++; $display("FAIL realign_err_clear: got %b want 00", FrmAlignErr); end
    step(2);
    compared++; if (FrmAlignDone !== 2'b11) begin mismatched++; $display("FAIL realign_done: got %b want 11", FrmAlignDone); end
  endtask

  task automatic test_loss_of_lock();
    int pulses = 0;
    prep(0, 0, 1'b0, 1'b0);
    BitClkDone = 1'b1;
    step(3);
    compared++; if (FrmAlignDone !== 2'b11) begin mismatched++; $display("FAIL lol_initial_lock: got %b want 11", FrmAlignDone); end
    corrupt[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k == 3) corrupt[0] = 1'b0;
      compared++; if (FrmAlignDone[0] !== 1'b1) begin mismatched++; $display("FAIL lol_three_hold: got %b want 1 at %0d", FrmAlignDone[0], k); end
    end
    corrupt[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      if (FrmBitslip[0] === 1'b1) pulses++;
    end
    compared++; if (FrmAlignDone[0] !== 1'b1) begin mismatched++; $display("FAIL lol_before_drop: got %b want 1", FrmAlignDone[0]); end
    step(1);
    corrupt[0] = 1'b0;
    compared++; if (FrmAlignDone !== 2'b10) begin mismatched++; $display("FAIL lol_drop: got %b want 10", FrmAlignDone); end
    compared++; if (FrmAllDone !== 1'b0) begin mismatched++; $display("FAIL lol_alldone_drop: got %b want 0", FrmAllDone); end
    for (int k = 1; k <= 2; k++) begin
      step(1);
      if (FrmBitslip[0] === 1'b1) pulses++;
    end
    compared++; if (FrmAlignDone !== 2'b11) begin mismatched++; $display("FAIL lol_relock: got %b want 11", FrmAlignDone); end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL lol_no_slip: got %0d want 0", pulses); end
  endtask

  task automatic test_two_lanes();
    int p0 = 0;
    int p1 = 0;
    prep(0, 5, 1'b0, 1'b0);
    BitClkDone = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (FrmBitslip[0] === 1'b1) p0++;
      if (FrmBitslip[1] === 1'b1) p1++;
      if (k == 3) begin
        compared++; if (FrmAlignDone !== 2'b01) begin mismatched++; $display("FAIL two_lane0_done: got %b want 01", FrmAlignDone); end
      end
      if (k == 27) begin
        compared++; if (FrmAllDone !== 1'b0) begin mismatched++; $display("FAIL two_alldone_early: got %b want 0", FrmAllDone); end
      end
      if (k == 28) begin
        compared++; if (FrmAllDone !== 1'b1) begin mismatched++; $display("FAIL two_alldone: got %b want 1", FrmAllDone); end
      end
    end
    compared++; if (p0 !== 0) begin mismatched++; $display("FAIL two_lane0_slips: got %0d want 0", p0); end
    compared++; if (p1 !== 5) begin mismatched++; $display("FAIL two_lane1_slips: got %0d want 5", p1); end
  endtask

  task automatic test_bitclk_drop();
    prep(3, 3, 1'b0, 1'b0);
    BitClkDone = 1'b1;
    step(2);
    compared++; if (FrmBitslip !== 2'b11) begin mismatched++; $display("FAIL drop_slip_cycle: got %b want 11", FrmBitslip); end
    BitClkDone = 1'b0;
    step(1);
    compared++; if (FrmBitslip !== 2'b00) begin mismatched++; $display("FAIL drop_pulse_width: got %b want 00", FrmBitslip); end
    step(2);
    compared++; if (FrmBitslip !== 2'b00) begin mismatched++; $display("FAIL drop_idle_slip: got %b want 00", FrmBitslip); end
    BitClkDone = 1'b1;
    step(1);
    compared++; if (FrmBitslip !== 2'b00) begin mismatched++; $display("FAIL drop_restart_check: got %b want 00", FrmBitslip); end
    step(1);
    compared++; if (FrmBitslip !== 2'b11) begin mismatched++; $display("FAIL drop_restart_slip: got %b want 11", FrmBitslip); end
  endtask

  task automatic test_reset_mid_settle();
    prep(3, 0, 1'b0, 1'b0);
    BitClkDone = 1'b1;
    step(3);
    compared++; if (FrmAlignDone !== 2'b10) begin mismatched++; $display("FAIL rst_pre_done: got %b want 10", FrmAlignDone); end
    FrmRstN = 1'b0;
    step(1);
    compared++; if (FrmAlignDone !== 2'b00) begin mismatched++; $display("FAIL rst_done: got %b want 00", FrmAlignDone); end
    compared++; if (FrmBitslip !== 2'b00) begin mismatched++; $display("FAIL rst_bitslip: got %b want 00", FrmBitslip); end
    compared++; if (FrmAlignErr !== 2'b00) begin mismatched++; $display("FAIL rst_err: got %b want 00", FrmAlignErr); end
    compared++; if (FrmAllDone !== 1'b0) begin mismatched++; $display("FAIL rst_alldone: got %b want 0", FrmAllDone); end
    FrmRstN = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_rotated();
    test_fail_and_realign();
    test_loss_of_lock();
    test_two_lanes();
    test_bitclk_drop();
    test_reset_mid_settle();
    compared++; if (wideSlip !== 1'b0) begin mismatched++; $display("FAIL slip_width: got %b want 0", wideSlip); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
